// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with false-start rejection, error flags and a valid/ready holding register.
// Build option: define UART_RX_PARITY_EN to add the parity bit stage (sense chosen by PARITY_ODD).
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 break_det,
    output logic                 busy
);
    // state  | meaning
    // IDLE   | line idle, waiting for rxs low
    // START  | confirming the start bit at half-bit
    // DATA   | sampling DATA_BITS data bits mid-bit
    // PARITY | sampling the parity bit
    // STOP   | sampling STOP_BITS stop bits, word completes on the last
    // BREAK  | line held low, waiting for release
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || OVERSAMPLE > 32 ||
        (OVERSAMPLE % 2) != 0 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx_param: illegal parameter set");
    end

    localparam int            TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1   = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    state_t               state_q;
    logic                 rx_s1_q, rx_s2_q;
    logic [TW-1:0]        tick_cnt_q;
    logic [3:0]           bit_cnt_q;
    logic                 stop_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] dout_q;
    logic                 frm_acc_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    logic          rxs;
    logic          mid_bit;
    logic [TW-1:0] tick_adv;
    logic          frame_bad;
    logic          accept;

    assign rxs       = rx_s2_q;
    assign mid_bit   = baud_tick && (tick_cnt_q == FULL_M1);
    assign tick_adv  = mid_bit ? '0 : tick_cnt_q + 1'b1;
    assign frame_bad = frm_acc_q || !rxs;
    assign accept    = rx_valid_q && rx_ready;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = 1'(PARITY_ODD);
    logic par_bad_q;
    logic parity_err_q;
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            shift_q     <= '0;
            frm_acc_q   <= 1'b0;
            dout_q      <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            overrun_q <= 1'b0;
            if (accept) begin
                rx_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        state_q    <= S_START;
                        tick_cnt_q <= '0;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        if (tick_cnt_q == HALF_M1) begin
                            tick_cnt_q <= '0;
                            bit_cnt_q  <= '0;
                            state_q    <= rxs ? S_IDLE : S_DATA;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        tick_cnt_q <= tick_adv;
                    end
                    if (mid_bit) begin
                        shift_q   <= {rxs, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            stop_cnt_q <= 1'b0;
                            frm_acc_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            state_q    <= S_PARITY;
`else
                            state_q    <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (baud_tick) begin
                        tick_cnt_q <= tick_adv;
                    end
                    if (mid_bit) begin
                        par_bad_q <= ((^shift_q) ^ rxs) != PAR_SENSE;
                        state_q   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_tick) begin
                        tick_cnt_q <= tick_adv;
                    end
                    if (mid_bit) begin
                        frm_acc_q  <= frame_bad;
                        stop_cnt_q <= stop_cnt_q + 1'b1;
                        // Last stop sample: the word completes now, mid-bit, so a
                        // back-to-back start edge is still seen from IDLE.
                        if (stop_cnt_q == LAST_STOP) begin
                            dout_q      <= shift_q;
                            frame_err_q <= frame_bad;
                            rx_valid_q  <= 1'b1;
                            overrun_q   <= rx_valid_q && !rx_ready;
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= par_bad_q;
`endif
                            state_q <= (!rxs && shift_q == '0) ? S_BREAK : S_IDLE;
                        end
                    end
                end
                S_BREAK: begin
                    if (rxs) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dout        = dout_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
    assign break_det   = (state_q == S_BREAK);
    assign busy        = (state_q != S_IDLE);

endmodule
